// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encodings and counter-width helper for the bit-serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between a requester and the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             cin;
  logic             busy;
  logic             done;
  logic             cout;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_full_adder.sv
// full_adder: gate-level one-bit full adder built from two half adders and an OR
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;
  half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .c(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .c(c2));
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell, WIDTH clocks per sum
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] sha, shb, sum_q;
  logic [CNT_W-1:0] cnt;
  logic carry, cout_q, done_q, fs, fc, last, accept;
  assign last     = cnt == CNT_W'(WIDTH - 1);
  assign accept   = bus.start && state != S_RUN;
  assign bus.busy = state == S_RUN;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  full_adder u_fa (.a(sha[0]), .b(shb[0]), .cin(carry), .s(fs), .cout(fc));
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end
  // next state: accept from IDLE/DONE, run WIDTH bits, pulse through DONE
  always_comb begin
    state_nx = accept ? S_RUN : (state == S_RUN) ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  // datapath: capture operands on accept, shift one bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha    <= '0;
      shb    <= '0;
      sum_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == S_RUN && last;
      if (accept) begin
        sha   <= bus.a;
        shb   <= bus.b;
        carry <= bus.cin;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        sha    <= sha >> 1;
        shb    <= shb >> 1;
        sum_q  <= {fs, sum_q[WIDTH-1:1]};
        carry  <= fc;
        cout_q <= fc;
        cnt    <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of the serial adder against plain arithmetic
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  serial_adder_if #(.WIDTH(W)) bus ();
  serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.cin   = cv;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic run_to_done(input string tag, input logic [W:0] expv, input int poke);
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, bus.busy, 1);
      check({tag, "_nodone"}, bus.done, 0);
      bus.start = (i == poke);
      bus.a     = (i == poke) ? 8'hFF : W'($urandom);
      bus.b     = (i == poke) ? 8'hFF : W'($urandom);
      bus.cin   = 1'($urandom);
      tick();
    end
    bus.start = 1'b0;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_idle"}, bus.busy, 0);
    check({tag, "_sum"}, bus.sum, expv[W-1:0]);
    check({tag, "_cout"}, bus.cout, expv[W]);
  endtask
  task automatic settle(input string tag, input logic [W:0] expv);
    tick();
    check({tag, "_pulse1"}, bus.done, 0);
    check({tag, "_hold"}, {bus.cout, bus.sum}, expv);
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    return (W+1)'(int'(av) + int'(bv) + int'(cv));
  endfunction
  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (2) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nostart_done", bus.done, 0);
      check("nostart_busy", bus.busy, 0);
    end
    launch(8'h3C, 8'h0F, 1'b0);
    run_to_done("add3c0f", 9'h04B, -1);
    settle("add3c0f", 9'h04B);
    launch(8'hFF, 8'h01, 1'b0);
    run_to_done("addff01", 9'h100, -1);
    settle("addff01", 9'h100);
    launch(8'h5A, 8'hA5, 1'b1);
    run_to_done("add5aa5", 9'h100, -1);
    settle("add5aa5", 9'h100);
    launch(8'h10, 8'h20, 1'b0);
    run_to_done("ignore", 9'h030, 3);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("ignore_single", bus.done, 0);
    end
    launch(8'h11, 8'h22, 1'b0);
    run_to_done("b2b_first", 9'h033, -1);
    launch(8'h01, 8'h02, 1'b0);
    run_to_done("b2b_second", 9'h003, -1);
    settle("b2b_second", 9'h003);
    launch(8'hFF, 8'hFF, 1'b1);
    repeat (4) tick();
    check("midrst_busy_pre", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cout", bus.cout, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("midrst_nodone", bus.done, 0);
      check("midrst_idle", bus.busy, 0);
    end
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      launch(ra, rb, rc);
      run_to_done("rand", model(ra, rb, rc), -1);
      if ($urandom_range(1, 0) == 0) settle("rand", model(ra, rb, rc));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
